// File: rtl/ray_dir_generator.sv
// ---------------------------------------------------------------------------
// ray_dir_generator
//
// Primary-ray direction source feeding the normalization pipeline. On a
// frame request it walks an H_RES x V_RES screen in raster order (y outer,
// x inner) and emits one un-normalized camera-space direction per cycle:
//   x = (px - H_RES/2) * PIXEL_SCALE
//   y = (V_RES/2 - py) * PIXEL_SCALE
//   z = -FOCAL
// All values are WIDTH-bit two's complement, Q_BITS fractional bits.
//
// Optional feature: define RAYGEN_JITTER_EN to add per-pixel sub-pixel
// jitter from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1).
// Without the macro no LFSR logic is built.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   frame_start  one-cycle frame request, honoured only when idle
//   stall        downstream not ready; freezes the whole block
//   dir_out      {x, y, z}, x in the most significant WIDTH bits
//   valid_out    dir_out holds a ray
//   pixel_x/y    screen coordinate of the ray on dir_out
//   last_out     high with valid_out for pixel (H_RES-1, V_RES-1)
//   busy         high from frame acceptance until the last ray is consumed
//   state_dbg    FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a ray is transferred on every rising edge where
// valid_out && !stall. While stall is high nothing inside the block moves,
// so dir_out/valid_out and all coordinates hold until the ray is taken.
// ---------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

module ray_dir_generator #(
    parameter int WIDTH       = `WIDTH,
    parameter int Q_BITS      = `Q_BITS,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int PIXEL_SCALE = 1 << (Q_BITS - 8),
    parameter int FOCAL       = 1 << Q_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       stall,
    output logic [3*WIDTH-1:0]         dir_out,
    output logic                       valid_out,
    output logic [$clog2(H_RES)-1:0]   pixel_x,
    output logic [$clog2(V_RES)-1:0]   pixel_y,
    output logic                       last_out,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    localparam logic [WIDTH-1:0] SCALE_W   = WIDTH'(PIXEL_SCALE);
    localparam logic [WIDTH-1:0] NEG_FOCAL = WIDTH'(-FOCAL);
    localparam logic [WIDTH-1:0] HALF_H    = WIDTH'(H_RES / 2);
    localparam logic [WIDTH-1:0] HALF_V    = WIDTH'(V_RES / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [XW-1:0]     cx_q;
    logic [YW-1:0]     cy_q;
    logic              busy_q;

    // Stage 1: screen-centred integer offsets.
    logic              s1_valid_q;
    logic              s1_last_q;
    logic [WIDTH-1:0]  s1_ox_q;
    logic [WIDTH-1:0]  s1_oy_q;
    logic [XW-1:0]     s1_x_q;
    logic [YW-1:0]     s1_y_q;

    // Stage 2: output registers.
    logic              valid_q;
    logic              last_q;
    logic [3*WIDTH-1:0] dir_q;
    logic [XW-1:0]     px_q;
    logic [YW-1:0]     py_q;

    logic              issue;
    logic              cx_wrap;
    logic              last_pix;
    logic [WIDTH-1:0]  ox_d;
    logic [WIDTH-1:0]  oy_d;
    logic [WIDTH-1:0]  dir_x_d;
    logic [WIDTH-1:0]  dir_y_d;
    logic [WIDTH-1:0]  jit_x;
    logic [WIDTH-1:0]  jit_y;

    assign issue    = (state_q == S_RUN) && !stall;
    assign cx_wrap  = (cx_q == XW'(H_RES - 1));
    assign last_pix = cx_wrap && (cy_q == YW'(V_RES - 1));

    // Coordinates are zero-extended before the subtraction so the result is
    // the signed offset from the screen centre in WIDTH-bit two's complement.
    assign ox_d = WIDTH'(cx_q) - HALF_H;
    assign oy_d = HALF_V - WIDTH'(cy_q);

    // The low WIDTH bits of a product are identical for signed and unsigned
    // operands, so a plain multiply yields the two's complement result.
    // Offset is an integer and PIXEL_SCALE is already in Q format, hence no
    // shift afterwards.
    assign dir_x_d = (s1_ox_q * SCALE_W) + jit_x;
    assign dir_y_d = (s1_oy_q * SCALE_W) + jit_y;

`ifdef RAYGEN_JITTER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr_q;
    logic [15:0] s1_jit_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // The value present when a pixel issues travels with it through S1, and
    // the register advances once per issued pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            s1_jit_q <= '0;
        end else if (!stall) begin
            if (state_q == S_IDLE && frame_start) begin
                lfsr_q <= LFSR_SEED;
            end else if (issue) begin
                lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            end
            if (issue) begin
                s1_jit_q <= lfsr_q;
            end
        end
    end

    assign jit_x = {{(WIDTH-8){s1_jit_q[7]}},  s1_jit_q[7:0]};
    assign jit_y = {{(WIDTH-8){s1_jit_q[15]}}, s1_jit_q[15:8]};
`else
    assign jit_x = '0;
    assign jit_y = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            busy_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_ox_q    <= '0;
            s1_oy_q    <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            dir_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
        end else if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q <= S_RUN;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cx_wrap) begin
                        cx_q <= '0;
                        cy_q <= last_pix ? '0 : cy_q + 1'b1;
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                    if (last_pix) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // stall is low here, so a valid last ray is consumed now.
                    if (valid_q && last_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            s1_valid_q <= issue;
            if (issue) begin
                s1_ox_q   <= ox_d;
                s1_oy_q   <= oy_d;
                s1_x_q    <= cx_q;
                s1_y_q    <= cy_q;
                s1_last_q <= last_pix;
            end

            valid_q <= s1_valid_q;
            last_q  <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                dir_q <= {dir_x_d, dir_y_d, NEG_FOCAL};
                px_q  <= s1_x_q;
                py_q  <= s1_y_q;
            end
        end
    end

    assign dir_out   = dir_q;
    assign valid_out = valid_q;
    assign pixel_x   = px_q;
    assign pixel_y   = py_q;
    assign last_out  = last_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ray_dir_generator.sv
`timescale 1ns/1ps
module tb_ray_dir_generator;

    localparam int W    = 32;
    localparam int Q    = 16;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int PS   = 32'h10000;
    localparam int F    = 32'h10000;
    localparam int XW   = $clog2(H);
    localparam int YW   = $clog2(V);
    localparam int RW   = 3*W + XW + YW + 1;
    localparam int NPIX = H * V;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic frame_start;
    logic stall;
    logic [3*W-1:0] dir_out;
    logic valid_out;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic last_out;
    logic busy;
    logic [1:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ray_dir_generator #(
        .WIDTH(W), .Q_BITS(Q), .H_RES(H), .V_RES(V),
        .PIXEL_SCALE(PS), .FOCAL(F)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .stall(stall),
        .dir_out(dir_out), .valid_out(valid_out), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .last_out(last_out), .busy(busy),
        .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: rays are packed {x, y, z, pixel_x, pixel_y, last}.
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] ref_ray(int k, int jx, int jy);
        int px;
        int py;
        longint dx;
        longint dy;
        longint dz;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic [XW-1:0] xw;
        logic [YW-1:0] yw;
        px = k % H;
        py = k / H;
        dx = longint'(px - H/2) * PS + jx;
        dy = longint'(V/2 - py) * PS + jy;
        dz = -longint'(F);
        x  = dx[W-1:0];
        y  = dy[W-1:0];
        z  = dz[W-1:0];
        xw = px[XW-1:0];
        yw = py[YW-1:0];
        return {x, y, z, xw, yw, (k == NPIX - 1)};
    endfunction

    // Appends one full frame of expected rays.
    task automatic build_exp();
`ifdef RAYGEN_JITTER_EN
        logic [15:0] lf;
        lf = 16'hACE1;
        for (int k = 0; k < NPIX; k++) begin
            exp_q.push_back(ref_ray(k, int'($signed(lf[7:0])), int'($signed(lf[15:8]))));
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
`else
        for (int k = 0; k < NPIX; k++) begin
            exp_q.push_back(ref_ray(k, 0, 0));
        end
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: applies inputs for the coming rising edge, records
    // the ray if it will be consumed there, and returns at the next negedge.
    task automatic step(input logic st, input logic fs);
        stall       = st;
        frame_start = fs;
        if (valid_out && !st) got_q.push_back({dir_out, pixel_x, pixel_y, last_out});
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dir_out !== '0) begin errors++; $display("FAIL reset_dir: got %h want 0", dir_out); end
        checks++; if (pixel_x !== '0 || pixel_y !== '0) begin errors++; $display("FAIL reset_pixel: got %0d,%0d want 0,0", pixel_x, pixel_y); end
        checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", last_out); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic test_basic_frame();
        int first_v;
        int last_v;
        int v_cyc;
        int busy_cyc;
        logic [RW-1:0] r0;
        logic [RW-1:0] rl;
        exp_q.delete(); got_q.delete(); build_exp();
        first_v = -1; last_v = -1; v_cyc = 0; busy_cyc = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (busy) busy_cyc++;
            if (valid_out) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                v_cyc++;
            end
            if (!busy) break;
            step(1'b0, 1'b0);
        end
        checks++; if (first_v !== 2) begin errors++; $display("FAIL basic_latency: first valid %0d cycles after RUN, want 2", first_v); end
        checks++; if (v_cyc !== NPIX || last_v - first_v + 1 !== NPIX) begin errors++; $display("FAIL basic_contiguous: %0d valid cycles span %0d, want %0d", v_cyc, last_v - first_v + 1, NPIX); end
        checks++; if (busy_cyc !== NPIX + 2) begin errors++; $display("FAIL basic_busy_len: got %0d want %0d", busy_cyc, NPIX + 2); end
        checks++; if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL basic_end_idle: busy %b state %0d want 0/0", busy, state_dbg); end
        r0 = (got_q.size() > 0) ? got_q[0] : '0;
        rl = (got_q.size() >= NPIX) ? got_q[NPIX-1] : '0;
`ifndef RAYGEN_JITTER_EN
        checks++; if (r0[RW-1 -: 3*W] !== {32'hFFFE0000, 32'h00010000, 32'hFFFF0000}) begin errors++; $display("FAIL basic_first_ray: got %h want fffe0000_00010000_ffff0000", r0[RW-1 -: 3*W]); end
        checks++; if (rl[RW-1 -: 2*W] !== {32'h00010000, 32'h00000000}) begin errors++; $display("FAIL basic_last_ray: got %h want 00010000_00000000", rl[RW-1 -: 2*W]); end
`endif
        checks++; if (rl[0] !== 1'b1 || r0[0] !== 1'b0) begin errors++; $display("FAIL basic_last_flag: first %b last %b want 0/1", r0[0], rl[0]); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall_mid();
        int held;
        int seen;
        logic [RW-1:0] cur;
        exp_q.delete(); got_q.delete(); build_exp();
        held = 0; seen = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (valid_out && pixel_x == 2 && pixel_y == 0) begin
                seen++;
                cur = {dir_out, pixel_x, pixel_y, last_out};
                checks++; if (cur !== exp_q[2]) begin errors++; $display("FAIL stall_mid_hold%0d: got %h want %h", seen, cur, exp_q[2]); end
                if (held < 5) begin
                    held++;
                    step(1'b1, 1'b0);
                    continue;
                end
            end
            if (!busy) break;
            step(1'b0, 1'b0);
        end
        checks++; if (seen !== 6) begin errors++; $display("FAIL stall_mid_seen: got %0d cycles want 6", seen); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_mid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_mid_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall_last();
        int held;
        exp_q.delete(); got_q.delete(); build_exp();
        held = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (valid_out && last_out && held < 4) begin
                step(1'b1, 1'b0);
                held++;
                checks++; if (busy !== 1'b1 || state_dbg !== ST_DRAIN) begin errors++; $display("FAIL stall_last_drain: busy %b state %0d want 1/%0d", busy, state_dbg, ST_DRAIN); end
                checks++; if (valid_out !== 1'b1 || last_out !== 1'b1) begin errors++; $display("FAIL stall_last_hold: valid %b last %b want 1/1", valid_out, last_out); end
                continue;
            end
            if (!busy) break;
            step(1'b0, 1'b0);
        end
        checks++; if (held !== 4) begin errors++; $display("FAIL stall_last_reached: stalled %0d cycles want 4", held); end
        checks++; if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL stall_last_release: busy %b state %0d want 0/0", busy, state_dbg); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_last_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_last_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_frame_start_in_run();
        logic pulsed;
        int extra;
        exp_q.delete(); got_q.delete(); build_exp();
        pulsed = 1'b0; extra = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (!pulsed && valid_out && got_q.size() == 4) begin
                checks++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL fs_run_state: got %0d want %0d", state_dbg, ST_RUN); end
                pulsed = 1'b1;
                step(1'b0, 1'b1);
                continue;
            end
            if (!busy) break;
            step(1'b0, 1'b0);
        end
        for (int c = 0; c < 20; c++) begin
            if (valid_out || busy) extra++;
            step(1'b0, 1'b0);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL fs_run_no_second_frame: %0d active cycles want 0", extra); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL fs_run_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fs_run_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); got_q.delete(); build_exp();
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (valid_out && got_q.size() == 5) begin
                reset = 1'b1;
                step(1'b0, 1'b0);
                reset = 1'b0;
                break;
            end
            step(1'b0, 1'b0);
        end
        checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_flags: valid %b busy %b want 0/0", valid_out, busy); end
        checks++; if (state_dbg !== ST_IDLE || last_out !== 1'b0) begin errors++; $display("FAIL reset_mid_state: state %0d last %b want 0/0", state_dbg, last_out); end
        checks++; if (dir_out !== '0 || pixel_x !== '0 || pixel_y !== '0) begin errors++; $display("FAIL reset_mid_data: dir %h px %0d py %0d want 0", dir_out, pixel_x, pixel_y); end
        got_q.delete();
        step(1'b0, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            step(1'b0, 1'b0);
        end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL reset_mid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int frames;
        exp_q.delete(); got_q.delete(); build_exp(); build_exp();
        frames = 0;
        step(1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                frames++;
                if (frames == 1) begin
                    step(1'b0, 1'b1);
                    continue;
                end
                break;
            end
            step(1'b0, 1'b0);
        end
        checks++; if (frames !== 2) begin errors++; $display("FAIL b2b_frames: got %0d want 2", frames); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ray%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stall();
        int pct;
        logic st;
        logic fs;
        logic prev_st;
        logic [RW+2:0] snap;
        logic [RW+2:0] now;
        for (int f = 0; f < 4; f++) begin
            exp_q.delete(); got_q.delete(); build_exp();
            pct = $urandom_range(10, 70);
            prev_st = 1'b0;
            snap = '0;
            step(1'b0, 1'b1);
            for (int c = 0; c < 2000; c++) begin
                now = {dir_out, pixel_x, pixel_y, last_out, valid_out, busy, state_dbg == ST_DRAIN};
                if (prev_st) begin
                    checks++; if (now !== snap) begin errors++; $display("FAIL rand_hold f%0d c%0d: got %h want %h", f, c, now, snap); end
                end
                if (!busy) break;
                snap = now;
                st = ($urandom_range(0, 99) < pct);
                fs = ($urandom_range(0, 7) == 0);
                step(st, fs);
                prev_st = st;
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_timeout f%0d: busy %b want 0", f, busy); end
            checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count f%0d: got %0d want %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_ray f%0d #%0d: got %h want %h", f, i, got_q[i], exp_q[i]); end
            end
            step(1'b0, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_stall_mid();
        test_stall_last();
        test_frame_start_in_run();
        test_reset_mid();
        test_back_to_back();
        test_random_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ray_dir_generator.md
Name: ray_dir_generator

Overview:
- Primary-ray direction source that sits directly upstream of the normalization pipeline.
- On a frame request, it walks every pixel of an H_RES x V_RES screen in raster order.
- For each pixel it emits one un-normalized camera-space RayDirection per cycle, which drives the normalizer's start/dir inputs.
- A stall input provides backpressure when the downstream buffers fill.

Parameters:
- WIDTH, `WIDTH, fixed-point word width of each direction component.
- Q_BITS, `Q_BITS, fractional bits of the fixed-point format.
- H_RES, 640, horizontal pixel count (even, >=2).
- V_RES, 480, vertical pixel count (even, >=2).
- PIXEL_SCALE, 1<<(Q_BITS-8), world-space width of one pixel in Q format.
- FOCAL, 1<<Q_BITS, distance to the image plane in Q format (positive).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- stall  input  1  downstream not ready; freezes the whole block.
- dir_out  output  RayDirection (3 x WIDTH)  un-normalized ray direction.
- valid_out  output  1  dir_out valid; the ray is consumed when valid_out && !stall.
- pixel_x  output  $clog2(H_RES)  x coordinate of the ray on dir_out.
- pixel_y  output  $clog2(V_RES)  y coordinate of the ray on dir_out.
- last_out  output  1  high with valid_out for pixel (H_RES-1, V_RES-1).
- busy  output  1  high from frame acceptance until the last ray is consumed.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. Reset has priority over all inputs, including mid-frame.
- Reset values: dir_out=0, valid_out=0, pixel_x=0, pixel_y=0, last_out=0, busy=0. FSM returns to IDLE and both pipeline stages are flushed (valid bits cleared).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on frame_start; counters cx=0, cy=0; busy=1 next cycle.
  - RUN: while !stall, issues pixel (cx,cy) into stage 1 each cycle. cx increments; at cx=H_RES-1 it wraps to 0 and cy increments. After issuing (H_RES-1,V_RES-1) the FSM goes to DRAIN.
  - DRAIN: no new issues. Goes to IDLE when the last ray is consumed (valid_out && last_out && !stall). busy drops in the same transition.
  - frame_start in RUN or DRAIN is ignored; no queueing.
- Pipeline, 2 stages, latency 2 cycles from issue to valid_out with no stall:
  - S1 (registered): ox = cx - H_RES/2; oy = V_RES/2 - cy. Both signed, WIDTH bits. Carries pixel coords and last flag.
  - S2 (registered): dir.x = ox*PIXEL_SCALE; dir.y = oy*PIXEL_SCALE; dir.z = -FOCAL.
    - The products are already in Q format: integer offset times Q value, so no shift is applied.
    - Keep the low WIDTH bits, two's complement. Multiplier may map to DSP.
- Stall: when stall=1, counters, S1, S2 and all outputs hold their values exactly. valid_out stays asserted if it was set. No ray is dropped or duplicated. A stall held across the RUN->DRAIN boundary delays the transition.
- Throughput: 1 ray/cycle; the frame takes H_RES*V_RES + 2 cycles with no stall.
- Ordering: strict raster order, y outer, x inner.
- Zero-length vector is impossible because dir.z != 0.

Optional Feature:
- Macro RAYGEN_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reloaded on reset and at each frame_start) advances once per issued pixel.
  - In S2, dir.x += sign-extended lfsr[7:0] and dir.y += sign-extended lfsr[15:8]. Each is scaled as signed Q fraction bits, giving sub-pixel jitter of less than 1/256 of the Q unit times 128.
  - The LFSR holds during stall.
- When undefined: no LFSR logic is built and outputs are exactly deterministic per the formulas above.

Test Plan:
- Basic frame (H_RES=4, V_RES=2, Q_BITS=16, PIXEL_SCALE=0x10000, FOCAL=0x10000, WIDTH=32), frame_start pulse -> 8 consecutive valid_out starting 2 cycles after RUN.
  - First ray: x=0xFFFE0000, y=0x00010000, z=0xFFFF0000.
  - Last ray (3,1): x=0x00010000, y=0x00000000, with last_out=1.
  - busy falls the next cycle.
- Stall mid-frame: assert stall for 5 cycles on the 3rd ray -> dir_out and pixel_x=2, pixel_y=0 held all 5 cycles. Exactly 8 unique rays are consumed, in raster order.
- Stall on last ray: stall=1 while last_out=1 -> FSM stays in DRAIN and busy=1 until stall drops.
- frame_start during RUN: pulse again at ray 4 -> ignored; the frame still yields exactly 8 rays and no second frame follows.
- Reset mid-frame at ray 5: next cycle valid_out=0, busy=0, IDLE. A new frame_start restarts at (0,0) with the same values as the basic frame.
- Back-to-back frames: frame_start in the cycle after busy falls -> second frame is identical. With RAYGEN_JITTER_EN, both frames show an identical jitter sequence (LFSR reseeded).
